// File: rtl/uart_rx.sv
// UART receiver: start(0), 8 data bits LSB first, one parity bit, stop(1).
// Each byte is presented with a one-cycle rx_valid strobe and parity/framing status.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_data_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_error,
   output logic       framing_error,
   output logic       rx_busy
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic          ODD  = (PARITY_ODD != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state;
   logic [1:0]    sync_q;
   logic          rx_s;
   logic          prev;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          par_bit;

   // NOTE: non-blocking assignments so both flops sample the pre-edge values.
   // Reset to 1 (idle level) so reset itself never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], rx_data_in};
   end

   assign rx_s = sync_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         prev          <= 1'b1;
         cnt           <= '0;
         idx           <= '0;
         shreg         <= '0;
         par_bit       <= 1'b0;
         rx_data       <= 8'h00;
         rx_valid      <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         rx_busy       <= 1'b0;
      end else begin
         prev     <= rx_s;
         rx_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               // Falling edge only, so a line stuck low cannot retrigger.
               if (prev && !rx_s) begin
                  state   <= START;
                  cnt     <= '0;
                  rx_busy <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF) begin
                  if (rx_s) begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end else begin
                     state <= DATA;
                     cnt   <= '0;
                     idx   <= '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == LAST) begin
                  shreg <= {rx_s, shreg[7:1]};
                  cnt   <= '0;
                  if (idx == 3'd7) state <= PARITY;
                  else             idx   <= idx + 3'd1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PARITY: begin
               if (cnt == LAST) begin
                  par_bit <= rx_s;
                  cnt     <= '0;
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == LAST) begin
                  state         <= IDLE;
                  cnt           <= '0;
                  rx_data       <= shreg;
                  parity_error  <= (^shreg) ^ par_bit ^ ODD;
                  framing_error <= ~rx_s;
                  rx_valid      <= 1'b1;
                  rx_busy       <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: two CLKS_PER_BIT=4 receivers (even/odd parity)
// on one line, plus a CLKS_PER_BIT=16 receiver on its own line for the glitch case.
module tb_uart_rx;

   logic clk = 1'b0;
   logic rst;
   logic line4;
   logic line16;

   logic [7:0] data4, data_odd, data16;
   logic       v4, v_odd, v16;
   logic       pe4, pe_odd, pe16;
   logic       fe4, fe_odd, fe16;
   logic       busy4, busy_odd, busy16;

   uart_rx #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) u_dut_even (
      .clk(clk), .rst(rst), .rx_data_in(line4),
      .rx_data(data4), .rx_valid(v4), .parity_error(pe4),
      .framing_error(fe4), .rx_busy(busy4));

   uart_rx #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u_dut_odd (
      .clk(clk), .rst(rst), .rx_data_in(line4),
      .rx_data(data_odd), .rx_valid(v_odd), .parity_error(pe_odd),
      .framing_error(fe_odd), .rx_busy(busy_odd));

   uart_rx #(.CLKS_PER_BIT(16), .PARITY_ODD(0)) u_dut_16 (
      .clk(clk), .rst(rst), .rx_data_in(line16),
      .rx_data(data16), .rx_valid(v16), .parity_error(pe16),
      .framing_error(fe16), .rx_busy(busy16));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         cyc;
   } rx_ev_t;

   rx_ev_t evq[$];
   int     cyc = 0;
   int     n_tests = 0;
   int     n_fail = 0;
   int     odd_cnt = 0;
   logic   odd_pe = 1'b1;
   int     v16_cnt = 0;
   logic   seen16 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (v4) evq.push_back('{d: data4, pe: pe4, fe: fe4, cyc: cyc});
      if (v_odd) begin
         odd_cnt <= odd_cnt + 1;
         odd_pe  <= pe_odd;
      end
      if (v16)    v16_cnt <= v16_cnt + 1;
      if (busy16) seen16  <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic rx_ev_t get_ev(input int i);
      rx_ev_t e;
      e = '{d: 8'h00, pe: 1'b0, fe: 1'b0, cyc: -1};
      if (i < evq.size()) e = evq[i];
      return e;
   endfunction

   task automatic bit4(input logic b);
      line4 = b;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_frame4(input logic [7:0] d, input logic p, input logic s);
      bit4(1'b0);
      for (int i = 0; i < 8; i++) bit4(d[i]);
      bit4(p);
      bit4(s);
   endtask

   task automatic idle4(input int n);
      line4 = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int     t0;
      int     odd_before;
      rx_ev_t ev0, ev1;

      rst    = 1'b1;
      line4  = 1'b1;
      line16 = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_data",  data4, 8'h00);
      check("rst_valid", v4, 1'b0);
      check("rst_pe",    pe4, 1'b0);
      check("rst_fe",    fe4, 1'b0);
      check("rst_busy",  busy4, 1'b0);
      idle4(5);

      // 0xA5, even parity 0: strobe 45 negedges after the line drop (E0+44).
      evq.delete();
      t0 = cyc;
      send_frame4(8'hA5, 1'b0, 1'b1);
      idle4(10);
      ev0 = get_ev(0);
      check("a5_count", evq.size(), 1);
      check("a5_data",  ev0.d, 8'hA5);
      check("a5_pe",    ev0.pe, 1'b0);
      check("a5_fe",    ev0.fe, 1'b0);
      check("a5_lat",   ev0.cyc - t0, 45);
      check("a5_busy",  busy4, 1'b0);

      // Back-to-back 0x00 and 0xFF with no idle gap.
      evq.delete();
      t0 = cyc;
      send_frame4(8'h00, 1'b0, 1'b1);
      send_frame4(8'hFF, 1'b0, 1'b1);
      idle4(10);
      ev0 = get_ev(0);
      ev1 = get_ev(1);
      check("b2b_count", evq.size(), 2);
      check("b2b_d0",    ev0.d, 8'h00);
      check("b2b_d1",    ev1.d, 8'hFF);
      check("b2b_err0",  {ev0.pe, ev0.fe}, 2'b00);
      check("b2b_err1",  {ev1.pe, ev1.fe}, 2'b00);
      check("b2b_lat",   ev0.cyc - t0, 45);
      check("b2b_gap",   ev1.cyc - ev0.cyc, 44);

      // 0x01 with parity 0: wrong for even, right for odd.
      evq.delete();
      odd_before = odd_cnt;
      send_frame4(8'h01, 1'b0, 1'b1);
      idle4(10);
      ev0 = get_ev(0);
      check("par_count",   evq.size(), 1);
      check("par_data",    ev0.d, 8'h01);
      check("par_pe_even", ev0.pe, 1'b1);
      check("par_fe_even", ev0.fe, 1'b0);
      check("par_odd_cnt", odd_cnt - odd_before, 1);
      check("par_pe_odd",  odd_pe, 1'b0);

      // 0x3C with stop 0, then line held low for 30 bit times.
      evq.delete();
      bit4(1'b0);
      for (int i = 0; i < 8; i++) bit4(1'(8'h3C >> i));
      bit4(1'b0);
      line4 = 1'b0;
      repeat (4 + 30 * 4) @(negedge clk);
      ev0 = get_ev(0);
      check("fe_count", evq.size(), 1);
      check("fe_data",  ev0.d, 8'h3C);
      check("fe_flag",  ev0.fe, 1'b1);
      check("fe_pe",    ev0.pe, 1'b0);
      check("fe_busy",  busy4, 1'b0);
      idle4(20);
      check("fe_norearm", evq.size(), 1);
      evq.delete();
      send_frame4(8'h81, 1'b0, 1'b1);
      idle4(10);
      ev0 = get_ev(0);
      check("rearm_count", evq.size(), 1);
      check("rearm_data",  ev0.d, 8'h81);
      check("rearm_fe",    ev0.fe, 1'b0);

      // One-cycle glitch on the CLKS_PER_BIT=16 receiver.
      line16 = 1'b0;
      @(negedge clk);
      line16 = 1'b1;
      repeat (40) @(negedge clk);
      check("gl_busy_seen", seen16, 1'b1);
      check("gl_valid_cnt", v16_cnt, 0);
      check("gl_data",      data16, 8'h00);
      check("gl_busy_end",  busy16, 1'b0);
      check("gl_err",       {pe16, fe16}, 2'b00);

      // Reset during data bit 4 of 0xF1; remaining bits are all 1.
      evq.delete();
      bit4(1'b0);
      bit4(1'b1);
      bit4(1'b0);
      bit4(1'b0);
      bit4(1'b0);
      line4 = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_busy", busy4, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_data",  data4, 8'h00);
      check("mid_rst_valid", v4, 1'b0);
      check("mid_rst_busy",  busy4, 1'b0);
      check("mid_rst_err",   {pe4, fe4}, 2'b00);
      idle4(40);
      check("mid_no_valid", evq.size(), 0);
      t0 = cyc;
      send_frame4(8'h5A, 1'b0, 1'b1);
      idle4(10);
      ev0 = get_ev(0);
      check("post_count", evq.size(), 1);
      check("post_data",  ev0.d, 8'h5A);
      check("post_err",   {ev0.pe, ev0.fe}, 2'b00);
      check("post_lat",   ev0.cyc - t0, 45);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
